// File: rtl/control_sequencer_if.sv
// Strobe bundle between the control sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
  parameter int OPW = 5
);
  logic [31:0]    ir;
  logic           stop;
  logic           run;
  logic           illegal;
  logic [OPW-1:0] opcode;
  logic read, write, MARin, MDRin, MDRout, IRin, PCin, PCout, incPC, Yin, Zin;
  logic ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout;
  logic BAout, Cout, InPortOut, OutPortIn;

  modport master (
    input  ir, stop,
    output run, illegal, opcode,
    output read, write, MARin, MDRin, MDRout, IRin, PCin, PCout, incPC, Yin, Zin,
    output ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout,
    output BAout, Cout, InPortOut, OutPortIn
  );

  modport slave (
    output ir, stop,
    input  run, illegal, opcode,
    input  read, write, MARin, MDRin, MDRout, IRin, PCin, PCout, incPC, Yin, Zin,
    input  ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout,
    input  BAout, Cout, InPortOut, OutPortIn
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, decode ir[31:27], execute T3-T7.
// Optional macro CS_ILLEGAL_TRAP_EN: illegal opcodes halt the sequencer and raise illegal.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(3);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(4);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(7);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(8);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(9);
  localparam logic [OPW-1:0] OP_AND  = OPW'(10);
  localparam logic [OPW-1:0] OP_OR   = OPW'(11);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(12);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(13);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(14);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(15);
  localparam logic [OPW-1:0] OP_LD   = OPW'(16);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(17);
  localparam logic [OPW-1:0] OP_ST   = OPW'(18);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(19);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(20);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(21);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(22);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(23);
  localparam logic [OPW-1:0] OP_IN   = OPW'(24);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(25);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  state_t         r_state;
  state_t         w_next;
  logic [OPW-1:0] w_op;
  logic           w_unused_ir;
  logic           w_alu2, w_unary, w_muldiv, w_ld, w_ldi, w_st, w_imm;
  logic           w_mf, w_in, w_out, w_nop, w_halt, w_illegal_op, w_last;

  assign w_op        = bus.ir[31 -: OPW];
  assign w_unused_ir = ^bus.ir[31-OPW:0];

  assign w_alu2 = w_op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_SHRA, OP_ROR,
                               OP_ROL, OP_AND, OP_OR, OP_XOR, OP_NOR};
  assign w_unary      = w_op inside {OP_NEG, OP_NOT};
  assign w_muldiv     = w_op inside {OP_MUL, OP_DIV};
  assign w_ld         = (w_op == OP_LD);
  assign w_ldi        = (w_op == OP_LDI);
  assign w_st         = (w_op == OP_ST);
  assign w_imm        = w_op inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign w_mf         = w_op inside {OP_MFHI, OP_MFLO};
  assign w_in         = (w_op == OP_IN);
  assign w_out        = (w_op == OP_OUT);
  assign w_nop        = (w_op == OP_NOP);
  assign w_halt       = (w_op == OP_HALT);
  assign w_illegal_op = (w_op < OP_ADD) || (w_op > OP_HALT);

  // Final execute state of the current instruction class (boundary where stop is honoured).
  always_comb begin
    w_last = 1'b0;
    unique case (r_state)
      S_T2:    w_last = w_nop || w_illegal_op;
      S_T3:    w_last = w_mf || w_in || w_out;
      S_T4:    w_last = w_unary;
      S_T5:    w_last = w_alu2 || w_ldi || w_imm;
      S_T6:    w_last = w_muldiv;
      S_T7:    w_last = 1'b1;
      default: w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET: w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: begin
        if (r_state == S_T2 && w_halt)
          w_next = S_HALT;
`ifdef CS_ILLEGAL_TRAP_EN
        else if (r_state == S_T2 && w_illegal_op)
          w_next = S_HALT;
`endif
        else if (w_last)
          w_next = bus.stop ? S_HALT : S_T0;
        else
          w_next = state_t'(r_state + 4'd1);
      end
    endcase
  end

`ifdef CS_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_RESET;
`ifdef CS_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
`ifdef CS_ILLEGAL_TRAP_EN
      if (r_state == S_T2 && w_illegal_op)
        r_illegal <= 1'b1;
`endif
    end
  end

  // Strobes decode directly from state so clr forces them low without waiting for a clock.
  always_comb begin
    bus.run      = (r_state != S_RESET) && (r_state != S_HALT);
    bus.opcode   = '0;
    bus.read     = 1'b0; bus.write    = 1'b0; bus.MARin     = 1'b0; bus.MDRin     = 1'b0;
    bus.MDRout   = 1'b0; bus.IRin     = 1'b0; bus.PCin      = 1'b0; bus.PCout     = 1'b0;
    bus.incPC    = 1'b0; bus.Yin      = 1'b0; bus.Zin       = 1'b0; bus.ZLowOut   = 1'b0;
    bus.ZHighOut = 1'b0; bus.HIin     = 1'b0; bus.LOin      = 1'b0; bus.HIout     = 1'b0;
    bus.LOout    = 1'b0; bus.Gra      = 1'b0; bus.Grb       = 1'b0; bus.Grc       = 1'b0;
    bus.Rin      = 1'b0; bus.Rout     = 1'b0; bus.BAout     = 1'b0; bus.Cout      = 1'b0;
    bus.InPortOut = 1'b0; bus.OutPortIn = 1'b0;
    unique case (r_state)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.incPC = 1'b1; bus.Zin = 1'b1; end
      S_T1: begin bus.ZLowOut = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: begin
        if (w_alu2 || w_muldiv || w_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (w_unary) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = w_op;
        end else if (w_ld || w_ldi || w_st) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else if (w_mf || w_in) begin
          bus.HIout = (w_op == OP_MFHI); bus.LOout = (w_op == OP_MFLO);
          bus.InPortOut = w_in; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (w_out) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortIn = 1'b1;
        end
      end
      S_T4: begin
        if (w_alu2 || w_muldiv) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = w_op;
        end else if (w_unary) begin
          bus.ZLowOut = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (w_ld || w_ldi || w_st || w_imm) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1;
          bus.opcode = (w_op == OP_ANDI) ? OP_AND : (w_op == OP_ORI) ? OP_OR : OP_ADD;
        end
      end
      S_T5: begin
        bus.ZLowOut = 1'b1;
        bus.Gra     = w_alu2 || w_ldi || w_imm;
        bus.Rin     = w_alu2 || w_ldi || w_imm;
        bus.LOin    = w_muldiv;
        bus.MARin   = w_ld || w_st;
      end
      S_T6: begin
        bus.ZHighOut = w_muldiv; bus.HIin = w_muldiv;
        bus.read     = w_ld;
        bus.MDRin    = w_ld || w_st;
        bus.Gra      = w_st; bus.Rout = w_st;
      end
      S_T7: begin
        bus.MDRout = w_ld; bus.Gra = w_ld; bus.Rin = w_ld;
        bus.write  = w_st;
      end
      default: ;
    endcase
  end
endmodule
